tmds_decode: RTL and testbench

- Receive-side TMDS channel decoder; the inverse of the channel encoder in the DVI path.
- Takes unaligned 10-bit parallel words from the per-channel deserializer.
- Finds the 10-bit symbol boundary by searching for control tokens, then decodes each symbol back to 8-bit data or the c1/c0 control pair, with de.
- One instance per TMDS channel, in the pixel clock domain.

---
 rtl/tmds_pkg.sv | 32 +++
 rtl/tmds_sym_decode.sv | 66 ++++++
 rtl/tmds_decode.sv | 248 ++++++++++++++++++++++++
 tb/tb_tmds_decode.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
//   Shared definitions for the TMDS channel encoder/decoder pair.
//   - CTRLTOKEN0..3 : the four 10-bit control symbols, indexed by {c1,c0}
//   - tmds_state_e  : symbol-alignment state (SEARCH / LOCKED)
//   - OFFSET_W / OFFSET_MAX : width and top value of the window offset
//   - next_offset() : advance the window offset with wrap 9 -> 0
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam logic [9:0] CTRLTOKEN0 = 10'b1101010100;  // {c1,c0} = 00
    localparam logic [9:0] CTRLTOKEN1 = 10'b0010101011;  // {c1,c0} = 01
    localparam logic [9:0] CTRLTOKEN2 = 10'b0101010100;  // {c1,c0} = 10
    localparam logic [9:0] CTRLTOKEN3 = 10'b1010101011;  // {c1,c0} = 11

    localparam int                 OFFSET_W   = 4;
    localparam logic [OFFSET_W-1:0] OFFSET_MAX = 4'd9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_e;

    // Slide the symbol window by one bit, wrapping after the last legal offset.
    function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
        if (off >= OFFSET_MAX) begin
            return '0;
        end
        return off + 1'b1;
    endfunction

endpackage

// File: rtl/tmds_sym_decode.sv
// -----------------------------------------------------------------------------
// tmds_sym_decode
//   Purely combinational decode of one aligned 10-bit TMDS symbol.
//   Control tokens yield de=0 with {c1,c0}; every other word is treated as a
//   data symbol and undone (optional inversion, then XOR/XNOR chain).
//
//   Ports:
//     w_i     in  10  aligned symbol
//     dout_o  out  8  decoded data (0 for control tokens)
//     c0_o    out  1  control bit 0 (0 for data)
//     c1_o    out  1  control bit 1 (0 for data)
//     de_o    out  1  1 = data symbol, 0 = control token
//     tok_o   out  1  w_i is one of the four control tokens
// -----------------------------------------------------------------------------
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [9:0] w_i,
    output logic [7:0] dout_o,
    output logic       c0_o,
    output logic       c1_o,
    output logic       de_o,
    output logic       tok_o
);

    logic [7:0] d;

    always_comb begin
        dout_o = '0;
        c0_o   = 1'b0;
        c1_o   = 1'b0;
        de_o   = 1'b0;
        tok_o  = 1'b0;
        d      = '0;

        case (w_i)
            CTRLTOKEN0: begin
                tok_o = 1'b1;
            end
            CTRLTOKEN1: begin
                tok_o = 1'b1;
                c0_o  = 1'b1;
            end
            CTRLTOKEN2: begin
                tok_o = 1'b1;
                c1_o  = 1'b1;
            end
            CTRLTOKEN3: begin
                tok_o = 1'b1;
                c0_o  = 1'b1;
                c1_o  = 1'b1;
            end
            default: begin
                de_o = 1'b1;
                // Bit 9 flags that the encoder inverted the payload for DC balance.
                d = w_i[9] ? ~w_i[7:0] : w_i[7:0];
                dout_o[0] = d[0];
                // Bit 8 records whether the encoder chained with XOR (1) or XNOR (0).
                for (int i = 1; i < 8; i++) begin
                    dout_o[i] = w_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_decode.sv
// -----------------------------------------------------------------------------
// tmds_decode
//   Receive-side TMDS channel decoder, one instance per channel, pixel clock
//   domain. Takes unaligned 10-bit words from the deserializer, finds the
//   symbol boundary by hunting for control tokens, and decodes each aligned
//   symbol to 8-bit data or the {c1,c0} control pair with de.
//
//   Parameters:
//     SEARCH_TIMEOUT  token-free cycles while searching before the window slides
//     LOCK_TOKENS     consecutive tokens at one offset needed to declare lock
//     LOSS_TIMEOUT    token-free cycles while locked before lock is dropped
//
//   Ports:
//     clkin          in   1  pixel clock
//     rstin          in   1  asynchronous active-high reset
//     din_raw        in  10  unaligned deserialized word, one per clkin
//     dout           out  8  decoded pixel data
//     c0, c1         out  1  decoded control bits
//     de             out  1  1 = data symbol, 0 = control symbol
//     locked         out  1  symbol alignment achieved
//     offset         out  4  current window offset 0..9 (debug)
//   Optional (build macro TMDS_LOCK_STATS_EN):
//     lock_loss_clr  in   1  synchronous clear of lock_loss_cnt
//     lock_loss_cnt  out  8  saturating count of LOCKED->SEARCH transitions
//
//   Latency: a word sampled at edge k is visible on the outputs after edge k+2.
// -----------------------------------------------------------------------------
module tmds_decode
    import tmds_pkg::*;
#(
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned LOCK_TOKENS    = 16,
    parameter int unsigned LOSS_TIMEOUT   = 65536
) (
    input  logic                clkin,
    input  logic                rstin,
    input  logic [9:0]          din_raw,
    output logic [7:0]          dout,
    output logic                c0,
    output logic                c1,
    output logic                de,
    output logic                locked,
    output logic [OFFSET_W-1:0] offset
`ifdef TMDS_LOCK_STATS_EN
    ,
    input  logic                lock_loss_clr,
    output logic [7:0]          lock_loss_cnt
`endif
);

    // Counter sizing: wide enough that the terminal compare never sees a wrap.
    localparam int unsigned TMO_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT
                                                                      : LOSS_TIMEOUT;
    localparam int TMO_W = $clog2(TMO_MAX) + 1;
    localparam int RUN_W = $clog2(LOCK_TOKENS) + 1;

    localparam logic [TMO_W-1:0] SEARCH_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] LOSS_LAST   = TMO_W'(LOSS_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(LOCK_TOKENS - 1);

    // Pipeline registers
    logic [9:0]          cur_q;
    logic [9:0]          prev_q;
    logic [9:0]          w_q;
    logic [9:0]          w_d;
    logic [7:0]          dout_q;
    logic                c0_q;
    logic                c1_q;
    logic                de_q;

    // Alignment FSM state
    tmds_state_e         state_q;
    tmds_state_e         state_d;
    logic [RUN_W-1:0]    run_q;
    logic [RUN_W-1:0]    run_d;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_d;
    logic [OFFSET_W-1:0] offset_q;
    logic [OFFSET_W-1:0] offset_d;
    logic                lock_lost;

    // Symbol decoder outputs
    logic [7:0]          sym_dout;
    logic                sym_c0;
    logic                sym_c1;
    logic                sym_de;
    logic                sym_tok;

    logic [19:0]         cat;

    // ---- Stage 1: capture raw word and keep the previous one ----
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= din_raw;
            prev_q <= cur_q;
        end
    end

    // ---- Stage 2: select the aligned 10-bit window ----
    // Offset 0 is cur alone; higher offsets pull low bits of prev into the top.
    always_comb begin
        cat = {prev_q, cur_q};
        w_d = 10'(cat >> offset_q);
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    tmds_sym_decode u_sym (
        .w_i    (w_q),
        .dout_o (sym_dout),
        .c0_o   (sym_c0),
        .c1_o   (sym_c1),
        .de_o   (sym_de),
        .tok_o  (sym_tok)
    );

    // ---- Stage 3: output register, held at zero until alignment is locked ----
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            dout_q <= '0;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            de_q   <= 1'b0;
        end else if (state_q == LOCKED) begin
            dout_q <= sym_dout;
            c0_q   <= sym_c0;
            c1_q   <= sym_c1;
            de_q   <= sym_de;
        end else begin
            dout_q <= '0;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            de_q   <= 1'b0;
        end
    end

    // Alignment FSM: state register
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            tmo_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            offset_q <= offset_d;
        end
    end

    // Alignment FSM: next-state logic.
    // A token always clears the timeout first, so it beats an expiry on the
    // same cycle. The window slides without flushing; the run restarts at 0.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        tmo_d    = tmo_q;
        offset_d = offset_q;

        case (state_q)
            SEARCH: begin
                if (sym_tok) begin
                    tmo_d = '0;
                    if (run_q == RUN_LAST) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                    if (tmo_q == SEARCH_LAST) begin
                        offset_d = next_offset(offset_q);
                        tmo_d    = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (sym_tok) begin
                    tmo_d = '0;
                end else if (tmo_q == LOSS_LAST) begin
                    state_d  = SEARCH;
                    offset_d = next_offset(offset_q);
                    run_d    = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Alignment FSM: outputs
    always_comb begin
        locked    = (state_q == LOCKED);
        lock_lost = (state_q == LOCKED) && (state_d == SEARCH);
    end

`ifdef TMDS_LOCK_STATS_EN
    logic [7:0] loss_cnt_q;
    logic [7:0] loss_cnt_d;

    // Clear has priority over a coincident loss; the count sticks at 255.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_loss_clr) begin
            loss_cnt_d = '0;
        end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost;
`endif

    assign dout   = dout_q;
    assign c0     = c0_q;
    assign c1     = c1_q;
    assign de     = de_q;
    assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decode.sv
// -----------------------------------------------------------------------------
// tb_tmds_decode
//   Randomized and directed stimulus for tmds_decode, checked every cycle
//   against a behavioural model of the alignment/decode rules, plus directed
//   checks at the points of interest (lock instant, offset slips, lock loss,
//   token-vs-timeout races, asynchronous reset). Short timeouts keep the run
//   small. Build with +define+TMDS_LOCK_STATS_EN to cover the loss counter.
// -----------------------------------------------------------------------------
module tb_tmds_decode;

    localparam int ST   = 64;
    localparam int LT   = 16;
    localparam int LOSS = 256;

    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

    logic       clkin = 1'b0;
    logic       rstin = 1'b1;
    logic [9:0] din_raw = '0;
    logic [7:0] dout;
    logic       c0, c1, de, locked;
    logic [3:0] offset;
    logic       lock_loss_clr = 1'b0;
`ifdef TMDS_LOCK_STATS_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [9:0]  m_cur, m_prev, m_w;
    logic [10:0] m_out;           // {dout, c1, c0, de}
    bit          m_lock;
    int          m_off, m_run, m_tmo, m_cnt;
    int          enc_disp = 0;
    logic [9:0]  wd;

    tmds_decode #(
        .SEARCH_TIMEOUT (ST),
        .LOCK_TOKENS    (LT),
        .LOSS_TIMEOUT   (LOSS)
    ) dut (
        .clkin   (clkin),
        .rstin   (rstin),
        .din_raw (din_raw),
        .dout    (dout),
        .c0      (c0),
        .c1      (c1),
        .de      (de),
        .locked  (locked),
        .offset  (offset)
`ifdef TMDS_LOCK_STATS_EN
        ,
        .lock_loss_clr (lock_loss_clr),
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_tok(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == TOK[k]) return 1'b1;
        return 1'b0;
    endfunction

    // {dout, c1, c0, de} straight from the symbol rules.
    function automatic logic [10:0] ref_decode(input logic [9:0] w);
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            if (w == TOK[k]) return {8'h00, k[1], k[0], 1'b0};
        end
        d = w[9] ? ~w[7:0] : w[7:0];
        return {d ^ {d[6:0], 1'b0} ^ (w[8] ? 8'h00 : 8'hFE), 2'b00, 1'b1};
    endfunction

    // Reference DVI encoder with running disparity.
    task automatic encode(input logic [7:0] dat, output logic [9:0] q);
        logic [8:0] qm;
        int n1, n1q, n0q;
        bit use_xnor;
        n1 = $countones(dat);
        use_xnor = (n1 > 4) || (n1 == 4 && !dat[0]);
        qm[0] = dat[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ dat[i]) : (qm[i-1] ^ dat[i]);
        qm[8] = ~use_xnor;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_disp += n1q - n0q - 2 * int'(!qm[8]);
        end
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (is_tok(w));
        return w;
    endfunction

    task automatic model_reset();
        m_cur = '0; m_prev = '0; m_w = '0; m_out = '0;
        m_lock = 1'b0; m_off = 0; m_run = 0; m_tmo = 0; m_cnt = 0;
    endtask

    // One clock edge of the model; every update uses pre-edge values.
    task automatic model_edge(input logic [9:0] din);
        bit          tok;
        logic [10:0] nout;
        logic [19:0] cat;
        logic [9:0]  nw;
        tok  = is_tok(m_w);
        nout = m_lock ? ref_decode(m_w) : 11'd0;
        cat  = {m_prev, m_cur};
        nw   = 10'(cat >> m_off);
        if (!m_lock) begin
            if (tok) begin
                m_tmo = 0;
                m_run++;
                if (m_run == LT) begin m_lock = 1'b1; m_run = 0; end
            end else begin
                m_run = 0;
                m_tmo++;
                if (m_tmo == ST) begin m_off = (m_off + 1) % 10; m_tmo = 0; end
            end
        end else begin
            if (tok) m_tmo = 0;
            else begin
                m_tmo++;
                if (m_tmo == LOSS) begin
                    m_lock = 1'b0; m_off = (m_off + 1) % 10; m_tmo = 0; m_run = 0;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        if (lock_loss_clr) m_cnt = 0;
        m_out = nout; m_w = nw; m_prev = m_cur; m_cur = din;
    endtask

    task automatic cycle(input logic [9:0] word);
        din_raw = word;
        @(posedge clkin);
        if (rstin) model_reset();
        else model_edge(word);
        #1;
        chk("out", {dout, c1, c0, de}, m_out);
        chk("align", {locked, offset}, {m_lock, 4'(m_off)});
`ifdef TMDS_LOCK_STATS_EN
        chk("lcnt", lock_loss_cnt, m_cnt);
`endif
    endtask

    task automatic send_check(input logic [9:0] word, input logic [7:0] exp);
        cycle(word);
        cycle(TOK[2]);
        cycle(TOK[2]);
        chk("dec", {dout, de}, {exp, 1'b1});
    endtask

    task automatic hold_reset();
        rstin = 1'b1;
        repeat (3) cycle(rand_data());
        rstin = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) cycle(10'h155);
        chk("rst_init", {dout, c1, c0, de, locked, offset}, 32'h0);
        rstin = 1'b0;

        // Random data while searching: outputs stay zero, no slip yet.
        repeat (20) cycle(rand_data());

        // Aligned lock on 16 tokens.
        repeat (LT) cycle(TOK[2]);
        cycle(TOK[2]);
        chk("lock_k1", locked, 1'b0);
        cycle(TOK[2]);
        chk("lock_k2", locked, 1'b1);
        cycle(TOK[2]);
        chk("ctl_10", {de, c1, c0}, 3'b010);

        // Data decode while locked.
        send_check(10'b0100000000, 8'h00);
        send_check(10'b1000000000, 8'hFF);
        encode(8'h00, wd);
        encode(8'hA5, wd); send_check(wd, 8'hA5);
        encode(8'hA5, wd); send_check(wd, 8'hA5);
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            encode(b, wd);
            send_check(wd, b);
        end

        // Random locked traffic with sparse tokens.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) cycle(TOK[$urandom_range(0, 3)]);
            else cycle(rand_data());
        end

        // Token on the exact loss-expiry cycle keeps lock.
        cycle(TOK[0]);
        repeat (LOSS - 1) cycle(rand_data());
        cycle(TOK[0]);
        repeat (4) cycle(TOK[0]);
        chk("race_lock", {locked, offset}, {1'b1, 4'd0});

        // Lock loss after LOSS_TIMEOUT token-free words.
        repeat (LOSS + 4) cycle(rand_data());
        chk("loss_lock", {locked, offset}, {1'b0, 4'd1});
        chk("loss_out", {dout, c1, c0, de}, 11'd0);
`ifdef TMDS_LOCK_STATS_EN
        chk("loss_cnt", lock_loss_cnt, 8'd1);
        lock_loss_clr = 1'b1;
        cycle(rand_data());
        lock_loss_clr = 1'b0;
        chk("loss_clr", lock_loss_cnt, 8'd0);
`endif

        // Asynchronous reset mid-stream.
        #1;
        rstin = 1'b1;
        #1;
        model_reset();
        chk("rst_async", {dout, c1, c0, de, locked, offset}, 32'h0);
        hold_reset();

        // Misaligned lock: token boundaries at offset 3.
        wd = {TOK[0][6:0], TOK[0][9:7]};
        repeat (100) cycle(wd);
        chk("slip1", {locked, offset}, {1'b0, 4'd1});
        repeat (60) cycle(wd);
        chk("slip2", {locked, offset}, {1'b0, 4'd2});
        repeat (100) cycle(wd);
        chk("mis_lock", {locked, offset}, {1'b1, 4'd3});
        chk("mis_ctl", {de, c1, c0}, 3'b000);

        // Token on the exact search-expiry cycle: no slip.
        hold_reset();
        repeat (ST - 3) cycle(rand_data());
        cycle(TOK[1]);
        repeat (40) cycle(rand_data());
        chk("race_srch", {locked, offset}, {1'b0, 4'd0});

        // Free-running random mix with token bursts.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) cycle(TOK[$urandom_range(0, 3)]);
            else cycle(10'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
